// File: rtl/adc_tone_meter.sv
// Receive-side tone meter: reciprocal-counts hysteresis-qualified rising crossings
// inside a fixed gate and reports frequency (DDS fword units) and peak-to-peak amplitude.
module adc_tone_meter #(
  parameter int ADC_WIDTH = 12,
  parameter int GATE_LOG2 = 12,
  parameter int HYST      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 adc_valid,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic                 meas_valid,
  output logic [31:0]          fword_out,
  output logic [ADC_WIDTH:0]   ppk_out,
  output logic [GATE_LOG2-1:0] cross_count,
  output logic                 no_signal,
  output logic                 busy
);

  localparam int W = ADC_WIDTH;
  localparam int G = GATE_LOG2;

  localparam logic signed [W-1:0] HYST_P  = W'(HYST);
  localparam logic signed [W-1:0] HYST_N  = -HYST_P;
  localparam logic signed [W-1:0] S_MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] S_MOST_POS = {1'b0, {(W-1){1'b1}}};

  // Handshake: adc_valid marks one sample per cycle with no backpressure;
  // meas_valid is a one-cycle pulse and the result outputs hold until the next pulse.

  typedef enum logic [1:0] {IDLE, GATE, DIV, DONE} state_t;
  state_t state;

  logic [G-1:0]          t_cnt;
  logic [G-1:0]          n_cnt;
  logic [G-1:0]          t_first;
  logic [G-1:0]          t_last;
  logic                  armed;
  logic signed [W-1:0]   s_max;
  logic signed [W-1:0]   s_min;
  logic                  seen;
  logic [G-1:0]          div_r;
  logic [G-1:0]          div_d;
  logic [31:0]           div_q;
  logic [4:0]            div_cnt;
  logic                  div_skip;

  logic signed [W-1:0]   s;
  logic                  sample_low;
  logic                  sample_high;
  logic                  crossing;
  logic                  gate_end;
  logic                  start_gate;
  logic [G-1:0]          n_nxt;
  logic [G-1:0]          tfirst_nxt;
  logic [G-1:0]          tlast_nxt;
  logic [G:0]            div_r2;
  logic                  div_ge;
  logic [G-1:0]          div_sub;
  logic [W:0]            ppk_full;

  // Offset-binary to two's complement is just an MSB flip.
  assign s = $signed({~adc_data[W-1], adc_data[W-2:0]});

  always_comb begin
    sample_low  = adc_valid && (s < HYST_N);
    sample_high = adc_valid && (s >= HYST_P);
    crossing    = (state == GATE) && armed && sample_high;
    gate_end    = (t_cnt == {G{1'b1}});
    start_gate  = enable && ((state == IDLE) || (state == DONE));

    n_nxt      = n_cnt;
    tfirst_nxt = t_first;
    tlast_nxt  = t_last;
    if (crossing) begin
      if (n_cnt != {G{1'b1}}) begin
        n_nxt = n_cnt + 1'b1;
      end
      tlast_nxt = t_cnt;
      if (n_cnt == '0) begin
        tfirst_nxt = t_cnt;
      end
    end

    // Remainder stays below the divisor, so it always fits in G bits.
    div_r2   = {div_r, 1'b0};
    div_ge   = (div_r2 >= {1'b0, div_d});
    div_sub  = div_r2[G-1:0] - div_d;
    ppk_full = {s_max[W-1], s_max} - {s_min[W-1], s_min};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      meas_valid  <= 1'b0;
      fword_out   <= '0;
      ppk_out     <= '0;
      cross_count <= '0;
      no_signal   <= 1'b0;
      busy        <= 1'b0;
      t_cnt       <= '0;
      n_cnt       <= '0;
      t_first     <= '0;
      t_last      <= '0;
      armed       <= 1'b0;
      s_max       <= '0;
      s_min       <= '0;
      seen        <= 1'b0;
      div_r       <= '0;
      div_d       <= '0;
      div_q       <= '0;
      div_cnt     <= '0;
      div_skip    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      case (state)
        IDLE: begin
          busy <= 1'b0;
        end

        GATE: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            t_cnt   <= t_cnt + 1'b1;
            n_cnt   <= n_nxt;
            t_first <= tfirst_nxt;
            t_last  <= tlast_nxt;
            if (sample_low) begin
              armed <= 1'b1;
            end else if (crossing) begin
              armed <= 1'b0;
            end
            if (adc_valid) begin
              seen <= 1'b1;
              if (s > s_max) s_max <= s;
              if (s < s_min) s_min <= s;
            end
            // Load the divider from the post-update values so a crossing
            // on the final gate cycle is included.
            if (gate_end) begin
              state    <= DIV;
              div_cnt  <= '0;
              div_q    <= '0;
              div_skip <= (n_nxt < G'(2));
              div_r    <= n_nxt - 1'b1;
              div_d    <= tlast_nxt - tfirst_nxt;
            end
          end
        end

        DIV: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (!div_skip) begin
              div_r <= div_ge ? div_sub : div_r2[G-1:0];
              div_q <= {div_q[30:0], div_ge};
            end
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == 5'd31) begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end
        end

        DONE: begin
          fword_out   <= div_skip ? 32'd0 : div_q;
          ppk_out     <= seen ? ppk_full : '0;
          cross_count <= n_cnt;
          no_signal   <= div_skip;
          meas_valid  <= 1'b1;
          state       <= IDLE;
          busy        <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Gate (re)start from IDLE or straight out of DONE; overrides the case above.
      if (start_gate) begin
        state   <= GATE;
        busy    <= 1'b1;
        t_cnt   <= '0;
        n_cnt   <= '0;
        t_first <= '0;
        t_last  <= '0;
        armed   <= 1'b0;
        seen    <= 1'b0;
        s_max   <= S_MOST_NEG;
        s_min   <= S_MOST_POS;
      end
    end
  end

endmodule

// File: tb/tb_adc_tone_meter.sv
// Bench for adc_tone_meter: table of single-gate measurements, then abort, reset-in-DIV
// and back-to-back corner sequences, all checked through an expected-result queue.
module tb_adc_tone_meter;

  localparam int W = 12;
  localparam int G = 12;
  localparam int LAT = (1 << G) + 33;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          adc_valid;
  logic [W-1:0]  adc_data;
  logic          meas_valid;
  logic [31:0]   fword_out;
  logic [W:0]    ppk_out;
  logic [G-1:0]  cross_count;
  logic          no_signal;
  logic          busy;

  adc_tone_meter #(.ADC_WIDTH(W), .GATE_LOG2(G), .HYST(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_valid(adc_valid), .adc_data(adc_data),
    .meas_valid(meas_valid), .fword_out(fword_out), .ppk_out(ppk_out),
    .cross_count(cross_count), .no_signal(no_signal), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  typedef struct {
    string        name;
    int           kind;    // 0 const, 1 square, 2 triangle
    int           period;
    int           lo;
    int           hi;
    int           vmode;   // 0 always valid, 1 even cycles only, 2 never valid
    logic [31:0]  fword;
    logic [W:0]   ppk;
    logic [G-1:0] cnt;
    logic         nosig;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  int checks;
  int failures;
  int cyc;
  int ph;
  int meas_cnt;
  int cur_kind, cur_period, cur_lo, cur_hi, cur_vmode;
  int sw_pending, sw_period;

  logic [57:0] exp_q[$];
  int          exp_at_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    int sv;
    int t;
    sv = 0;
    case (cur_kind)
      1: sv = ((ph % cur_period) < (cur_period / 2)) ? cur_lo : cur_hi;
      2: begin
        t  = ph % (4 * cur_hi);
        sv = (t < 2 * cur_hi) ? (t - cur_hi) : (3 * cur_hi - t);
      end
      default: sv = 0;
    endcase
    adc_data  = W'(sv + 2048);
    adc_valid = (cur_vmode == 0) || ((cur_vmode == 1) && (ph % 2 == 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    ph++;
    if (sw_pending != 0 && ph == LAT) begin
      ph         = 0;
      cur_period = sw_period;
      sw_pending = 0;
    end
    drive();
  endtask

  task automatic set_wave(input vec_t v);
    cur_kind   = v.kind;
    cur_period = v.period;
    cur_lo     = v.lo;
    cur_hi     = v.hi;
    cur_vmode  = v.vmode;
  endtask

  task automatic push_exp(input vec_t v, input int at);
    exp_q.push_back({v.fword, v.ppk, v.cnt, v.nosig});
    exp_at_q.push_back(at);
  endtask

  task automatic wait_meas(input int target, input int budget);
    int start;
    start = cyc;
    while (meas_cnt < target && (cyc - start) < budget) tick();
    chk("meas_arrived", 64'(meas_cnt), 64'(target));
  endtask

  task automatic chk_outputs(input string tag, input vec_t v);
    chk({tag, "_fword"}, 64'(fword_out), 64'(v.fword));
    chk({tag, "_ppk"},   64'(ppk_out),   64'(v.ppk));
    chk({tag, "_cnt"},   64'(cross_count), 64'(v.cnt));
    chk({tag, "_nosig"}, 64'(no_signal), 64'(v.nosig));
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (meas_valid) begin
      logic [57:0] e;
      int at;
      meas_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_meas_valid actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e  = exp_q.pop_front();
        at = exp_at_q.pop_front();
        chk("fword_out",   64'(fword_out),   64'(e[57:26]));
        chk("ppk_out",     64'(ppk_out),     64'(e[25:13]));
        chk("cross_count", 64'(cross_count), 64'(e[12:1]));
        chk("no_signal",   64'(no_signal),   64'(e[0]));
        chk("latency",     64'(cyc),         64'(at));
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    checks = 0; failures = 0; cyc = 0; ph = 0; meas_cnt = 0;
    cur_kind = 0; cur_period = 64; cur_lo = 0; cur_hi = 0; cur_vmode = 0;
    sw_pending = 0; sw_period = 64;
    rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; adc_data = '0;

    vecs[0] = '{"const",     0,  64,     0,    0, 0, 32'h0000_0000,    0,   0, 1'b1};
    vecs[1] = '{"tri15",     2,   0,   -15,   15, 0, 32'h0000_0000,   30,   0, 1'b1};
    vecs[2] = '{"hyst16",    1,  64,   -16,   16, 0, 32'h0000_0000,   32,   0, 1'b1};
    vecs[3] = '{"novalid",   1,  64, -1000, 1000, 2, 32'h0000_0000,    0,   0, 1'b1};
    vecs[4] = '{"sq32",      1,  32,   -20,   20, 0, 32'h0800_0000,   40, 128, 1'b0};
    vecs[5] = '{"sq100",     1, 100, -1000, 1000, 0, 32'h028F_5C28, 2000,  41, 1'b0};
    vecs[6] = '{"hyst17",    1,  64,   -17,   17, 0, 32'h0400_0000,   34,  64, 1'b0};
    vecs[7] = '{"altvalid",  1,  64, -1000, 1000, 1, 32'h0400_0000, 2000,  64, 1'b0};
    vecs[8] = '{"fullscale", 1,  64, -2048, 2047, 0, 32'h0400_0000, 4095,  64, 1'b0};
    vecs[9] = '{"sq64",      1,  64, -1000, 1000, 0, 32'h0400_0000, 2000,  64, 1'b0};

    repeat (3) tick();
    chk("rst_meas_valid", 64'(meas_valid), 64'd0);
    chk("rst_fword",      64'(fword_out),  64'd0);
    chk("rst_ppk",        64'(ppk_out),    64'd0);
    chk("rst_cnt",        64'(cross_count), 64'd0);
    chk("rst_nosig",      64'(no_signal),  64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // Single-gate measurements, phase-aligned to gate cycle 0.
    for (int i = 0; i < NV; i++) begin
      set_wave(vecs[i]);
      push_exp(vecs[i], cyc + 1 + LAT);
      enable = 1'b1;
      ph     = -1;
      wait_meas(meas_cnt + 1, LAT + 200);
      enable = 1'b0;
      repeat (3) tick();
      chk({vecs[i].name, "_busy_after"}, 64'(busy), 64'd0);
    end

    // Abort: enable dropped at gate cycle 1000.
    begin
      int m0;
      set_wave(vecs[9]);
      m0     = meas_cnt;
      enable = 1'b1;
      ph     = -1;
      while (ph < 1000) tick();
      chk("abort_busy_high", 64'(busy), 64'd1);
      enable = 1'b0;
      tick();
      chk("abort_busy_low", 64'(busy), 64'd0);
      repeat (3300) tick();
      chk("abort_no_meas", 64'(meas_cnt), 64'(m0));
      chk_outputs("abort_hold", vecs[9]);
    end

    // Reset asserted at DIV cycle 10, then a clean measurement.
    set_wave(vecs[9]);
    enable = 1'b1;
    ph     = -1;
    while (ph < (1 << G) + 10) tick();
    rst = 1'b1;
    #1;
    chk("divrst_meas_valid", 64'(meas_valid), 64'd0);
    chk("divrst_fword",      64'(fword_out),  64'd0);
    chk("divrst_ppk",        64'(ppk_out),    64'd0);
    chk("divrst_cnt",        64'(cross_count), 64'd0);
    chk("divrst_nosig",      64'(no_signal),  64'd0);
    chk("divrst_busy",       64'(busy),       64'd0);
    repeat (2) tick();
    rst = 1'b0;
    push_exp(vecs[9], cyc + 1 + LAT);
    ph = -1;
    wait_meas(meas_cnt + 1, LAT + 200);
    enable = 1'b0;
    repeat (3) tick();

    // Continuous: period 64 then period 100 in the very next gate.
    set_wave(vecs[9]);
    sw_pending = 1;
    sw_period  = 100;
    push_exp(vecs[9], cyc + 1 + LAT);
    push_exp(vecs[5], cyc + 1 + 2 * LAT);
    enable = 1'b1;
    ph     = -1;
    wait_meas(meas_cnt + 2, 2 * LAT + 200);
    enable = 1'b0;
    repeat (3) tick();
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
